clock_step_ctrl: RTL and testbench
==================================

Name: clock_step_ctrl

Overview:
- Parametrised successor to the fixed free-running slow-clock divider that feeds the student core on the board top.
- Generates a 50%-duty slow clock, clk_div, plus a matching one-cycle tick from the board clock.
- The divide ratio is selectable at run time.
- Two debounced buttons add run/pause toggle and single-step, so student designs can be paced or stepped one cycle at a time.
- Instantiated in the board top between the board clock/keys and the top-level core's clk_2 input.

Parameters:
- DIV_MAX, 100000000, divisor at rate_sel=0 (board-clock cycles per slow period).
- NRATE_BITS, 2, width of rate_sel.
- RATE_SHIFT, 2, right-shift of DIV_MAX per rate step.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level.

Ports:
- clk, input, 1, board clock (50 MHz).
- reset, input, 1, synchronous, active-high.
- rate_sel, input, NRATE_BITS, divide-rate select.
- btn_run, input, 1, raw asynchronous button, active-high (board top inverts KEY); each press toggles run/pause.
- btn_step, input, 1, raw asynchronous button, active-high; each press in pause produces one slow cycle.
- clk_div, output, 1, registered slow clock.
- tick, output, 1, one-cycle pulse coincident with every clk_div rising edge.
- running, output, 1, 1 in RUN state.
- cycle_count, output, 32, slow rising edges since reset; only present with CYCLE_COUNT_EN.

Behaviour:
- Reset values: clk_div=0, tick=0, running=1, cycle_count=0, cnt=0, state=RUN, debounced levels=0. Reset mid-period aborts the period immediately.
- Divisor: D = DIV_MAX >> (RATE_SHIFT*rate_sel), clamped to a minimum of 2. H = D/2 (floor).
- D is registered only at the period start (the wrap), so a rate change never shortens or glitches the current period.
- Period counter cnt runs 0..D-1:
  - At the edge where cnt wraps to 0 and a period starts: clk_div<=1 and tick<=1 for one cycle.
  - At the edge where cnt reaches H: clk_div<=0.
  - Result: high for H cycles, low for D-H cycles.
- Button path:
  - 2-FF synchroniser, then debouncer. The debounced level updates only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is the debounced rising edge, one cycle wide. Releases produce no event.
- State machine:
  - RUN: free-running periods. A run press sets pause_req. When clk_div falls (cnt reaches H) with pause_req set: go to PAUSE and clear pause_req. The period still completes its low phase with no further tick. clk_div always rests low.
  - PAUSE: cnt held at 0, clk_div=0, no tick.
    - Step press: go to STEP; the next cycle is a wrap (tick, clk_div rises).
    - Run press: go to RUN; the next cycle starts a period.
  - STEP: exactly one full period of D cycles, then return to PAUSE. If a run press arrived during STEP, go to RUN instead.
    - Further step presses during STEP are dropped, not queued.
- Simultaneous run and step presses in PAUSE: run wins; step is dropped.
- Step presses in RUN are ignored.
- running = (state==RUN).

Optional Feature:
- Macro CYCLE_COUNT_EN.
  - Defined: cycle_count port exists; it increments by 1 on every tick, wraps 0xFFFFFFFF->0, and reset clears it.
  - Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
All scenarios use DIV_MAX=16, RATE_SHIFT=1, NRATE_BITS=2, DEBOUNCE_CYCLES=4.
- Reset then rate_sel=0 for 64 cycles -> 4 ticks spaced 16 cycles apart; clk_div high 8 and low 8; running=1.
- rate_sel 0->3 asserted mid-period -> the current 16-cycle period completes, then periods are 2 cycles (high 1, low 1); rate_sel=2 gives 4-cycle periods.
- btn_run held 4 cycles mid-high-phase -> clk_div falls at cnt=8, running=0, no ticks for 100 cycles, clk_div stays 0.
- In PAUSE, btn_step pulses with bounce (1,0,1,1,1,1) -> exactly one tick, clk_div high 8 cycles and low 8, then back in PAUSE; a second step press during that period produces no extra tick.
- In PAUSE, btn_run and btn_step pressed together -> running=1, periodic ticks resume, no step executed; assert reset mid-STEP -> clk_div=0, state RUN next cycle.
- With CYCLE_COUNT_EN: 10 ticks -> cycle_count=10; preload 0xFFFFFFFF by force, one tick -> 0.

Source files
------------

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl
//   Run-time selectable slow-clock generator for pacing the student core.
//   Produces a 50%-duty registered slow clock (clk_div) and a one-cycle tick
//   that coincides with every clk_div rising edge. Two debounced buttons
//   toggle run/pause and single-step one slow period at a time.
//
// Parameters
//   DIV_MAX          board-clock cycles per slow period at rate_sel = 0
//   NRATE_BITS       width of rate_sel
//   RATE_SHIFT       right-shift of DIV_MAX applied per rate step
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a button level
//
// Ports
//   clk          in   board clock
//   reset        in   synchronous, active-high
//   rate_sel     in   divide-rate select, D = DIV_MAX >> (RATE_SHIFT*rate_sel), min 2
//   btn_run      in   raw button, active-high; each press toggles run/pause
//   btn_step     in   raw button, active-high; each press in pause runs one period
//   clk_div      out  registered slow clock, high D/2 cycles, low D - D/2 cycles
//   tick         out  one-cycle pulse with every clk_div rising edge
//   running      out  1 while free-running
//   cycle_count  out  slow rising edges since reset (only with CYCLE_COUNT_EN)
//
// Optional feature
//   `define CYCLE_COUNT_EN adds the cycle_count port and its 32-bit counter.

module clock_step_ctrl #(
    parameter int DIV_MAX         = 100000000,
    parameter int NRATE_BITS      = 2,
    parameter int RATE_SHIFT      = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRATE_BITS-1:0] rate_sel,
    input  logic                  btn_run,
    input  logic                  btn_step,
    output logic                  clk_div,
    output logic                  tick,
    output logic                  running
`ifdef CYCLE_COUNT_EN
    ,
    output logic [31:0]           cycle_count
`endif
);

    // The period counter must hold the largest divisor, which is never below 2.
    localparam int D_MAX   = (DIV_MAX < 2) ? 2 : DIV_MAX;
    localparam int CNT_W   = $clog2(D_MAX + 1);
    localparam int DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PAUSE = 2'd1,
        S_STEP  = 2'd2
    } state_t;

    // Divisor for a rate select, saturated at the low end so the slow clock
    // always has at least one high and one low cycle.
    function automatic logic [CNT_W-1:0] divisor(input logic [NRATE_BITS-1:0] sel);
        logic [31:0] d;
        d = 32'(DIV_MAX) >> (RATE_SHIFT * int'(sel));
        if (d < 32'd2) begin
            d = 32'd2;
        end
        return CNT_W'(d);
    endfunction

    // ------------------------------------------------------------------
    // Button path: bit 0 = run, bit 1 = step
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] press;

    assign btn_raw = {btn_step, btn_run};

    // Stage p0/p1: two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_debounce
        logic            lvl_q;
        logic            lvl_d1_q;
        logic [DB_W-1:0] stable_cnt_q;

        // A new level is accepted only after it has persisted for
        // DEBOUNCE_CYCLES consecutive cycles; any return to the current
        // level restarts the count.
        always_ff @(posedge clk) begin
            if (reset) begin
                lvl_q        <= 1'b0;
                lvl_d1_q     <= 1'b0;
                stable_cnt_q <= '0;
            end else begin
                lvl_d1_q <= lvl_q;
                if (sync_p1[i] == lvl_q) begin
                    stable_cnt_q <= '0;
                end else if (stable_cnt_q == DB_LAST) begin
                    lvl_q        <= sync_p1[i];
                    stable_cnt_q <= '0;
                end else begin
                    stable_cnt_q <= stable_cnt_q + DB_W'(1);
                end
            end
        end

        // Rising edge of the debounced level only; releases are silent.
        assign press[i] = lvl_q & ~lvl_d1_q;
    end

    logic run_press;
    logic step_press;

    assign run_press  = press[0];
    assign step_press = press[1];

    // ------------------------------------------------------------------
    // Period generator and run/pause/step control
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic             start_q;       // first edge after reset begins a period
    logic             pause_req_q;
    logic             pause_req_d;
    logic             resume_req_q;
    logic             resume_req_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] div_q;         // divisor latched at the period start
    logic [CNT_W-1:0] half;
    logic             at_last;
    logic             at_fall;
    logic             wrap;
    logic             fall;
    logic             park;
    logic             clk_div_d;
    logic             tick_d;

    assign half    = div_q >> 1;
    assign at_last = (cnt_q == div_q - CNT_W'(1));
    assign at_fall = (cnt_q == half - CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        pause_req_d  = pause_req_q;
        resume_req_d = resume_req_q;
        wrap         = 1'b0;
        fall         = 1'b0;
        park         = 1'b0;

        case (state_q)
            S_RUN: begin
                // Step presses are meaningless while free-running.
                if (run_press) begin
                    pause_req_d = 1'b1;
                end
                if (start_q || at_last) begin
                    wrap = 1'b1;
                end else if (at_fall) begin
                    fall = 1'b1;
                    // Pausing on the falling edge leaves clk_div resting low.
                    if (pause_req_q) begin
                        state_d     = S_PAUSE;
                        pause_req_d = 1'b0;
                    end
                end
            end

            S_PAUSE: begin
                park = 1'b1;
                // Run has priority over a simultaneous step press.
                if (run_press) begin
                    state_d = S_RUN;
                    wrap    = 1'b1;
                    park    = 1'b0;
                end else if (step_press) begin
                    state_d = S_STEP;
                    wrap    = 1'b1;
                    park    = 1'b0;
                end
            end

            S_STEP: begin
                // Extra step presses are dropped; a run press is remembered
                // and honoured when the stepped period ends.
                if (run_press) begin
                    resume_req_d = 1'b1;
                end
                if (at_last) begin
                    resume_req_d = 1'b0;
                    if (resume_req_q || run_press) begin
                        state_d = S_RUN;
                        wrap    = 1'b1;
                    end else begin
                        state_d = S_PAUSE;
                        park    = 1'b1;
                    end
                end else if (at_fall) begin
                    fall = 1'b1;
                end
            end

            default: begin
                state_d = S_RUN;
                wrap    = 1'b1;
            end
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        clk_div_d = clk_div;
        tick_d    = 1'b0;
        if (wrap) begin
            cnt_d     = '0;
            clk_div_d = 1'b1;
            tick_d    = 1'b1;
        end else if (park) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
        end else if (fall) begin
            clk_div_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RUN;
            start_q      <= 1'b1;
            pause_req_q  <= 1'b0;
            resume_req_q <= 1'b0;
            cnt_q        <= '0;
            clk_div      <= 1'b0;
            tick         <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= 1'b0;
            pause_req_q  <= pause_req_d;
            resume_req_q <= resume_req_d;
            cnt_q        <= cnt_d;
            clk_div      <= clk_div_d;
            tick         <= tick_d;
        end
    end

    // The divisor is sampled only when a period starts, so a rate change
    // never shortens or glitches the period in flight. It needs no reset:
    // the first edge after reset is always a period start that loads it.
    always_ff @(posedge clk) begin
        if (wrap) begin
            div_q <= divisor(rate_sel);
        end
    end

    assign running = (state_q == S_RUN);

`ifdef CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= 32'd0;
        end else if (tick) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Testbench for clock_step_ctrl (DIV_MAX=16, RATE_SHIFT=1, NRATE_BITS=2,
// DEBOUNCE_CYCLES=4). Each expected slow period is pushed as {gap since
// previous tick, high length} when the stimulus that causes it is driven;
// a negedge monitor pops one entry per observed tick.

module tb_clock_step_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  rate_sel;
    logic        btn_run;
    logic        btn_step;
    logic        clk_div;
    logic        tick;
    logic        running;
`ifdef CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    clock_step_ctrl #(
        .DIV_MAX         (16),
        .NRATE_BITS      (2),
        .RATE_SHIFT      (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rate_sel (rate_sel),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .clk_div  (clk_div),
        .tick     (tick),
        .running  (running)
`ifdef CYCLE_COUNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, want, $time);
        end
    endtask

    typedef struct {
        int gap;   // 0 = first period after reset/pause, gap not checked
        int high;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input int gap, input int high, input int n);
        exp_t e;
        e.gap  = gap;
        e.high = high;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
        end
    endtask

    // Monitor
    int nidx      = 0;
    int last_tick = 0;
    int hl        = 0;
    int pend_high = 0;
    int ticks_seen = 0;
    bit hl_active = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        nidx++;
        if (reset) begin
            hl_active = 1'b0;
        end else begin
            if (tick) begin
                ticks_seen++;
                if (exp_q.size() == 0) begin
                    chk("tick_unexpected", tick, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.gap != 0) begin
                        chk("period", nidx - last_tick, e.gap);
                    end
                    pend_high = e.high;
                    hl_active = 1'b1;
                    hl        = 0;
                end
                last_tick = nidx;
            end
            if (hl_active) begin
                if (clk_div) begin
                    hl++;
                end else begin
                    chk("high_len", hl, pend_high);
                    hl_active = 1'b0;
                end
            end
        end
    end

    // Stimulus: `now` is the index of the last clock edge, edge 0 being the
    // first edge after reset is released. go_to(k) returns 1 time unit after
    // edge k.
    int now;

    task automatic go_to(input int k);
        while (now < k) begin
            @(posedge clk);
            #1;
            now++;
        end
    endtask

    initial begin
        int hc;
        int t0;
        reset    = 1'b1;
        rate_sel = 2'd0;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk_div", clk_div, 0);
        chk("rst_tick", tick, 0);
        chk("rst_running", running, 1);
`ifdef CYCLE_COUNT_EN
        chk("rst_cycle_count", cycle_count, 0);
`endif

        // Free run at D=16: ticks at 0,16,32,48,64
        now   = -1;
        reset = 1'b0;
        push_exp(0, 8, 1);
        push_exp(16, 8, 4);
        go_to(10);
        chk("run_running", running, 1);

        // Rate 3 mid-period: the 16-cycle period completes, then D=2
        go_to(68);
        rate_sel = 2'd3;
        push_exp(16, 1, 1);
        push_exp(2, 1, 4);
        go_to(89);
        rate_sel = 2'd2;
        push_exp(2, 2, 1);
        push_exp(4, 2, 2);
        go_to(99);
        rate_sel = 2'd0;
        push_exp(4, 8, 1);
        push_exp(16, 8, 1);

        // Run press around the tick at 118: pause at that period's fall (126)
        go_to(117);
        btn_run = 1'b1;
        go_to(121);
        btn_run = 1'b0;
        go_to(126);
        chk("pause_running", running, 0);
        chk("pause_clk_div", clk_div, 0);
        hc = 0;
        t0 = ticks_seen;
        for (int i = 0; i < 100; i++) begin
            go_to(now + 1);
            hc += int'(clk_div);
        end
        chk("pause_clk_hi", hc, 0);
        chk("pause_ticks", ticks_seen - t0, 0);

        // Bouncy step press -> one full period at 239, back to pause
        go_to(230);
        t0 = ticks_seen;
        push_exp(0, 8, 1);
        btn_step = 1'b1; go_to(231);
        btn_step = 1'b0; go_to(232);
        btn_step = 1'b1; go_to(236);
        btn_step = 1'b0;
        go_to(243);
        btn_step = 1'b1;     // second press during STEP, must be dropped
        go_to(247);
        btn_step = 1'b0;
        go_to(256);
        chk("step_running", running, 0);
        chk("step_clk_div", clk_div, 0);
        go_to(300);
        chk("step_ticks", ticks_seen - t0, 1);

        // Run and step together in pause: run wins, periodic ticks from 307
        push_exp(0, 8, 1);
        push_exp(16, 8, 1);
        btn_run  = 1'b1;
        btn_step = 1'b1;
        go_to(304);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        go_to(308);
        chk("both_running", running, 1);

        // Pause again, then step and reset mid-STEP
        go_to(322);
        btn_run = 1'b1;
        go_to(326);
        btn_run = 1'b0;
        go_to(332);
        chk("pause2_running", running, 0);
        go_to(340);
        push_exp(0, 8, 1);
        btn_step = 1'b1;
        go_to(344);
        btn_step = 1'b0;
        go_to(350);
        chk("step2_clk_div", clk_div, 1);
        go_to(351);
        reset = 1'b1;
        go_to(352);
        chk("midstep_rst_clk_div", clk_div, 0);
        chk("midstep_rst_tick", tick, 0);
        chk("midstep_rst_running", running, 1);
        reset = 1'b0;
        push_exp(0, 8, 1);
        push_exp(16, 8, 10);
        go_to(354);
        chk("post_rst_running", running, 1);

`ifdef CYCLE_COUNT_EN
        go_to(500);
        chk("cycle_count_10", cycle_count, 10);
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        go_to(501);
        release dut.cycle_cnt_q;
        go_to(510);
        chk("cycle_count_pre", cycle_count, 64'h0000_0000_FFFF_FFFF);
        go_to(515);
        chk("cycle_count_wrap", cycle_count, 0);
`endif

        go_to(516);
        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
